// File: rtl/pipe_stage_reg.sv
// Elastic pipeline register: DEPTH valid/ready stages carrying a datapath and a control bundle,
// with bubble collapsing, synchronous flush and NOP masking of control on empty output.
module pipe_stage_reg #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 8,
    parameter int DEPTH  = 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              InValid,
    output logic              InReady,
    input  logic [DATA_W-1:0] InData,
    input  logic [CTRL_W-1:0] InCtrl,
    output logic              OutValid,
    input  logic              OutReady,
    output logic [DATA_W-1:0] OutData,
    output logic [CTRL_W-1:0] OutCtrl,
    input  logic              Flush,
    output logic [CNT_W-1:0]  Occupancy
);

    logic [DEPTH-1:0]  valid;
    logic [DEPTH-1:0]  validNext;
    logic [DEPTH-1:0]  adv;
    logic [DEPTH-1:0]  load;
    logic [DATA_W-1:0] dataQ [DEPTH];
    logic [CTRL_W-1:0] ctrlQ [DEPTH];
    logic [CNT_W-1:0]  occNext;
    logic              alive;
    logic              accept;

    // A stage advances when the one ahead of it is empty or itself advancing, so bubbles collapse
    // even while the output is stalled.
    always_comb begin
        adv = '0;
        adv[DEPTH-1] = valid[DEPTH-1] & OutReady;
        for (int k = DEPTH - 2; k >= 0; k--) begin
            adv[k] = valid[k] & (~valid[k+1] | adv[k+1]);
        end
        load = ~valid | adv;
    end

    // alive keeps InReady low until the first edge after reset release.
    assign InReady = alive & ~Flush & load[0];
    assign accept  = InValid & InReady;

    always_comb begin
        validNext    = valid;
        validNext[0] = load[0] ? accept : valid[0];
        for (int k = 1; k < DEPTH; k++) begin
            validNext[k] = load[k] ? valid[k-1] : valid[k];
        end
        if (Flush) begin
            validNext = '0;
        end
        occNext = '0;
        for (int k = 0; k < DEPTH; k++) begin
            occNext = occNext + CNT_W'(validNext[k]);
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            alive     <= 1'b0;
            valid     <= '0;
            Occupancy <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                dataQ[k] <= '0;
                ctrlQ[k] <= '0;
            end
        end else begin
            alive     <= 1'b1;
            valid     <= validNext;
            Occupancy <= occNext;
            if (accept) begin
                dataQ[0] <= InData;
                ctrlQ[0] <= InCtrl;
            end
            // Payload only moves with a real entry, so held stages keep stable data.
            for (int k = 1; k < DEPTH; k++) begin
                if (load[k] && valid[k-1]) begin
                    dataQ[k] <= dataQ[k-1];
                    ctrlQ[k] <= ctrlQ[k-1];
                end
            end
        end
    end

    assign OutValid = valid[DEPTH-1];
    assign OutData  = dataQ[DEPTH-1];
    assign OutCtrl  = valid[DEPTH-1] ? ctrlQ[DEPTH-1] : '0;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg at DEPTH=2 and DEPTH=3 with a per-instance scoreboard queue.
module tb_pipe_stage_reg;

    logic        Clk;
    logic        Rst_n;

    logic        inValid2, inReady2, outValid2, outReady2, flush2;
    logic [31:0] inData2, outData2;
    logic [7:0]  inCtrl2, outCtrl2;
    logic [1:0]  occ2;

    logic        inValid3, inReady3, outValid3, outReady3, flush3;
    logic [31:0] inData3, outData3;
    logic [7:0]  inCtrl3, outCtrl3;
    logic [1:0]  occ3;

    logic [39:0] q2 [$];
    logic [39:0] q3 [$];
    int          nChecks;
    int          nPass;

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .DEPTH(2)) u2 (
        .Clk(Clk), .Rst_n(Rst_n),
        .InValid(inValid2), .InReady(inReady2), .InData(inData2), .InCtrl(inCtrl2),
        .OutValid(outValid2), .OutReady(outReady2), .OutData(outData2), .OutCtrl(outCtrl2),
        .Flush(flush2), .Occupancy(occ2)
    );

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .DEPTH(3)) u3 (
        .Clk(Clk), .Rst_n(Rst_n),
        .InValid(inValid3), .InReady(inReady3), .InData(inData3), .InCtrl(inCtrl3),
        .OutValid(outValid3), .OutReady(outReady3), .OutData(outData3), .OutCtrl(outCtrl3),
        .Flush(flush3), .Occupancy(occ3)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        nChecks = nChecks + 1;
        assert (obs === exp) nPass = nPass + 1;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Scoreboard update for both instances, sampled mid-cycle before the edge.
    task automatic monitor();
        logic [39:0] e;
        if (!outValid2) chk("mask2", 40'(outCtrl2), 40'h0);
        if (!outValid3) chk("mask3", 40'(outCtrl3), 40'h0);
        if (outValid2 && outReady2) begin
            if (q2.size() == 0) chk("spurious2", 40'(outValid2), 40'h0);
            else begin
                e = q2.pop_front();
                chk("out2_data", 40'(outData2), 40'(e[39:8]));
                chk("out2_ctrl", 40'(outCtrl2), 40'(e[7:0]));
            end
        end
        if (outValid3 && outReady3) begin
            if (q3.size() == 0) chk("spurious3", 40'(outValid3), 40'h0);
            else begin
                e = q3.pop_front();
                chk("out3_data", 40'(outData3), 40'(e[39:8]));
                chk("out3_ctrl", 40'(outCtrl3), 40'(e[7:0]));
            end
        end
        if (inValid2 && inReady2) q2.push_back({inData2, inCtrl2});
        if (inValid3 && inReady3) q3.push_back({inData3, inCtrl3});
        if (flush2) q2.delete();
        if (flush3) q3.delete();
    endtask

    task automatic cycle();
        @(negedge Clk);
        monitor();
        @(posedge Clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && (q2.size() > 0 || q3.size() > 0); i++) cycle();
        chk("drain2", 40'(q2.size()), 40'h0);
        chk("drain3", 40'(q3.size()), 40'h0);
    endtask

    initial begin
        nChecks = 0;
        nPass   = 0;
        Rst_n   = 1'b0;
        {inValid2, outReady2, flush2, inData2, inCtrl2} = '0;
        {inValid3, outReady3, flush3, inData3, inCtrl3} = '0;

        // Reset state
        repeat (3) @(posedge Clk);
        #1;
        chk("rst_outvalid", 40'(outValid2), 40'h0);
        chk("rst_outctrl",  40'(outCtrl2),  40'h0);
        chk("rst_outdata",  40'(outData2),  40'h0);
        chk("rst_occ",      40'(occ2),      40'h0);
        chk("rst_inready",  40'(inReady2),  40'h0);
        #3 Rst_n = 1'b1;
        @(posedge Clk);
        #1;
        chk("rel_inready2", 40'(inReady2), 40'h1);
        chk("rel_inready3", 40'(inReady3), 40'h1);

        // Steady stream, DEPTH=2
        outReady2 = 1'b1; inValid2 = 1'b1; inCtrl2 = 8'h81; inData2 = 32'h10;
        cycle();
        chk("lat_v_early", 40'(outValid2), 40'h0);
        chk("lat_occ1",    40'(occ2),      40'h1);
        inData2 = 32'h11;
        cycle();
        chk("lat_v",    40'(outValid2), 40'h1);
        chk("lat_data", 40'(outData2),  40'h10);
        chk("lat_ctrl", 40'(outCtrl2),  40'h81);
        inData2 = 32'h12;
        cycle();
        chk("steady_occ", 40'(occ2),     40'h2);
        chk("steady_d1",  40'(outData2), 40'h11);
        inValid2 = 1'b0;
        drain();

        // Back-pressure, DEPTH=2
        outReady2 = 1'b0; inValid2 = 1'b1;
        inData2 = 32'hA0; inCtrl2 = 8'h12;
        cycle();
        inData2 = 32'hB0; inCtrl2 = 8'h34;
        cycle();
        inData2 = 32'hC0; inCtrl2 = 8'h56;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("bp_inready", 40'(inReady2), 40'h0);
            chk("bp_occ",     40'(occ2),     40'h2);
            chk("bp_hold",    40'(outData2), 40'hA0);
        end
        outReady2 = 1'b1;
        #1;
        chk("bp_release_ready", 40'(inReady2), 40'h1);
        cycle();
        inValid2 = 1'b0;
        drain();

        // Bubble collapse, DEPTH=3
        outReady3 = 1'b0; inValid3 = 1'b1; inData3 = 32'hC0; inCtrl3 = 8'hC1;
        cycle();
        inValid3 = 1'b0;
        cycle();
        cycle();
        inValid3 = 1'b1; inData3 = 32'hD0; inCtrl3 = 8'hD1;
        cycle();
        inValid3 = 1'b0;
        chk("bc_occ_pre",   40'(occ3),      40'h2);
        chk("bc_out",       40'(outData3),  40'hC0);
        chk("bc_inready",   40'(inReady3),  40'h1);
        cycle();
        chk("bc_occ",       40'(occ3),      40'h2);
        chk("bc_inready2",  40'(inReady3),  40'h1);
        chk("bc_hold",      40'(outData3),  40'hC0);

        // Flush, DEPTH=3
        inValid3 = 1'b1; inData3 = 32'hE0; inCtrl3 = 8'hE1;
        cycle();
        chk("fl_full_occ",   40'(occ3),     40'h3);
        chk("fl_full_ready", 40'(inReady3), 40'h0);
        flush3 = 1'b1; outReady3 = 1'b1; inData3 = 32'hF0; inCtrl3 = 8'hF1;
        #1;
        chk("fl_inready", 40'(inReady3), 40'h0);
        cycle();
        flush3 = 1'b0; inValid3 = 1'b0;
        chk("fl_occ",   40'(occ3),      40'h0);
        chk("fl_valid", 40'(outValid3), 40'h0);
        chk("fl_ctrl",  40'(outCtrl3),  40'h0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("fl_noaccept", 40'(outValid3), 40'h0);
        end

        // Async reset mid-stream, DEPTH=2
        outReady2 = 1'b0; inValid2 = 1'b1; inData2 = 32'h55; inCtrl2 = 8'h66;
        cycle();
        inData2 = 32'h77; inCtrl2 = 8'h88;
        cycle();
        inValid2 = 1'b0;
        chk("ar_occ_pre", 40'(occ2), 40'h2);
        #2 Rst_n = 1'b0;
        #1;
        chk("ar_valid", 40'(outValid2), 40'h0);
        chk("ar_ctrl",  40'(outCtrl2),  40'h0);
        chk("ar_occ",   40'(occ2),      40'h0);
        q2.delete();
        q3.delete();
        #2 Rst_n = 1'b1;
        @(posedge Clk);
        #1;
        outReady2 = 1'b1; inValid2 = 1'b1; inData2 = 32'h99; inCtrl2 = 8'h5A;
        cycle();
        inValid2 = 1'b0;
        chk("ar_lat_early", 40'(outValid2), 40'h0);
        cycle();
        chk("ar_lat_v",    40'(outValid2), 40'h1);
        chk("ar_lat_data", 40'(outData2),  40'h99);
        chk("ar_lat_ctrl", 40'(outCtrl2),  40'h5A);
        drain();

        // NOP masking: bubbles with all control bits set
        inValid2 = 1'b0; inCtrl2 = 8'hFF; inData2 = 32'hDEAD;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("nop_valid", 40'(outValid2), 40'h0);
            chk("nop_ctrl",  40'(outCtrl2),  40'h0);
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised, elastic successor to the fixed MEM/WB-style pipeline register.
- Carries a DATA_W datapath bundle and a CTRL_W control bundle through DEPTH register stages, using a valid/ready handshake.
- Supports synchronous flush, bubble collapsing and NOP masking of control bits.
- Placed between any two pipeline stages (ID/EX, EX/MEM, MEM/WB) so stall and flush handling live in one block instead of ad-hoc per-stage registers.

Parameters:
- DATA_W, 32, width of datapath payload (results, load data, PC+4 concatenated by the instantiator)
- CTRL_W, 8, width of control payload (RegWrite, MemToReg, Link, RegDst, ...)
- DEPTH, 1, number of register stages; legal range 1..4
- CNT_W, $clog2(DEPTH+1), width of the Occupancy output; derived, not overridden

Ports:
- Clk  input  1  rising-edge clock
- Rst_n  input  1  asynchronous active-low reset
- InValid  input  1  upstream presents a valid entry
- InReady  output  1  block accepts an entry this cycle
- InData  input  DATA_W  upstream datapath payload
- InCtrl  input  CTRL_W  upstream control payload
- OutValid  output  1  last stage holds a valid entry
- OutReady  input  1  downstream consumes the entry this cycle
- OutData  output  DATA_W  last-stage datapath payload
- OutCtrl  output  CTRL_W  last-stage control payload, forced 0 when OutValid=0
- Flush  input  1  synchronous kill of all held entries
- Occupancy  output  CNT_W  number of valid entries held

Behaviour:
- Reset: Rst_n=0 clears all stage valid bits and all data/ctrl registers to 0 asynchronously. While in reset, OutValid=0, OutCtrl=0, OutData=0, Occupancy=0, InReady=0. InReady returns to 1 in the first cycle after Rst_n deasserts.
- Stage k (0 = input side, DEPTH-1 = output side) holds valid bit V[k] plus data and ctrl registers.
- Advance rule: adv[DEPTH-1] = V[DEPTH-1] & OutReady. For k < DEPTH-1, adv[k] = V[k] & (~V[k+1] | adv[k+1]). This collapses bubbles: a younger entry moves into an empty slot even when the output is stalled.
- Load rule: stage k loads from k-1 (or from the input when k=0) when it is empty or advancing.
- InReady = ~Flush & (~V[0] | adv[0]). This is combinational from OutReady; downstream must not derive OutReady from InReady.
- Accept: an entry is accepted when InValid & InReady. Its data and ctrl are captured into stage 0 at that edge.
- Latency: DEPTH cycles from accept to OutValid with no back-pressure. Throughput is 1 entry/cycle.
- Hold: a stage that neither loads nor is emptied keeps its data and ctrl unchanged. OutData is stable while OutValid=1 and OutReady=0.
- NOP masking: OutCtrl = V[DEPTH-1] ? ctrl[DEPTH-1] : 0. Bubbles therefore never assert RegWrite or any other write enable. OutData is not masked.
- Occupancy: popcount of V[]. It is registered consistently with V, so it reads 0..DEPTH.
- Flush, on the next edge:
  - All V cleared. Data registers are not required to clear.
  - No input is accepted in the Flush cycle (InReady=0).
  - An entry presented with OutValid=1 and OutReady=1 in the Flush cycle counts as consumed; all other entries are discarded.
- Full (Occupancy=DEPTH) with OutReady=0: InReady=0 and all stages hold.
- Full with OutReady=1: the whole chain shifts and InReady=1, so there are no lost cycles.
- Empty: OutValid=0 and OutCtrl=0. An entry accepted with DEPTH=1 appears on the next cycle.
- Reset mid-operation: in-flight entries are discarded immediately, with no partial outputs.
- InValid=0 is accepted as a bubble: nothing is loaded and V[0] clears if stage 0 advances.

Test Plan:
- Reset and steady stream: DEPTH=2, OutReady=1, InValid=1, InData=0x10,0x11,0x12 on consecutive cycles, InCtrl=0x81 -> OutValid rises 2 cycles after the first accept, OutData = 0x10,0x11,0x12 on consecutive cycles, OutCtrl=0x81, Occupancy=2 in steady state.
- Back-pressure: DEPTH=2, two entries A=0xA0, B=0xB0 loaded, OutReady=0 for 3 cycles -> InReady=0, Occupancy=2, OutData=0xA0 held. OutReady=1 -> A then B delivered, with InReady=1 in the same cycle A leaves.
- Bubble collapse: DEPTH=3, entry C=0xC0 held at the output with OutReady=0, stage 1 empty, D=0xD0 in stage 0 -> next cycle D moves to stage 1, InReady=1, Occupancy=2.
- Flush: DEPTH=3, three entries held, Flush=1 with OutReady=1 -> the output entry is consumed that cycle. Next cycle Occupancy=0, OutValid=0, OutCtrl=0x00, and InData presented during Flush is not accepted.
- Async reset mid-stream: drop Rst_n between clock edges while Occupancy=2 -> OutValid, OutCtrl and Occupancy go to 0 immediately without a clock edge. The first entry after release emerges DEPTH cycles after its accept.
- NOP masking: InValid=0 with InCtrl=0xFF -> OutCtrl stays 0x00 and OutValid=0 at all cycles.
